mem_bank_ctrl: RTL
==================

MEM_BANK_CTRL -- requirements
Module: mem_bank_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL provide parameter BANK_W, default 2, bank-select bits (2^BANK_W banks).
REQ-003 SHALL provide parameter OFF_W, default 10, in-bank offset bits (2^OFF_W words per bank).
REQ-004 SHALL provide parameter RD_LAT, default 2, read latency in cycles; legal range 1..4.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port cen  input  1  chip enable, active low.
REQ-008 SHALL have port rd  input  1  read request.
REQ-009 SHALL have port wr  input  1  write request.
REQ-010 SHALL have port add  input  BANK_W+OFF_W  address: add[MSB -: BANK_W] = bank, add[OFF_W-1:0] = offset.
REQ-011 SHALL have port din  input  DATA_W  write data.
REQ-012 SHALL have port dout  output  DATA_W  read data, registered.
REQ-013 SHALL have port dout_vld  output  1  one-cycle pulse qualifying dout.
REQ-014 SHALL have port busy  output  1  high while the array is being cleared.
REQ-015 SHALL have port err  output  1  one-cycle pulse flagging a rejected request.

Function
REQ-016 SHALL implement two states: CLEAR and ACTIVE.
REQ-017 CLEAR: an offset counter SHALL step 0..2^OFF_W-1, writing zero to that offset in every bank in parallel, one offset per cycle.
REQ-018 CLEAR -> ACTIVE SHALL occur on the edge that writes offset 2^OFF_W-1; busy SHALL be high throughout CLEAR and low from the following cycle.
REQ-019 A request is accepted only when the state is ACTIVE, cen=0, and exactly one of rd/wr is 1.
REQ-020 Accepted write: mem[bank][offset] <= din on the accepting edge.
REQ-021 Accepted read: the array SHALL be sampled on the accepting edge; dout and dout_vld SHALL update RD_LAT edges after acceptance.
REQ-022 Reads SHALL be fully pipelined: one read per cycle, returned in request order.
REQ-023 A read accepted on the edge after a write to the same address SHALL return the newly written data.
REQ-024 rd=1 and wr=1 with cen=0 SHALL produce no array access and an err pulse on the following cycle.
REQ-025 A request (rd or wr) with cen=0 during CLEAR SHALL be dropped, with an err pulse on the following cycle.
REQ-026 cen=1 SHALL suppress all new requests without raising err; dout SHALL hold its last value, and in-flight reads SHALL still complete.
REQ-027 dout SHALL hold its value between dout_vld pulses.
REQ-028 Address bits SHALL map directly to a bank/offset pair; there is no wrap and no out-of-range address.

Reset
REQ-029 rst=1 on an edge SHALL: set the state to CLEAR, reset the counter to 0, flush the read pipeline, and set dout=0, dout_vld=0, err=0, busy=1.
REQ-030 While rst is held, the counter SHALL stay at 0 and busy=1; the sweep SHALL begin on the first edge with rst=0.
REQ-031 rst mid-operation SHALL discard all in-flight reads; no dout_vld pulse occurs for them.
REQ-032 The array SHALL reach all-zero contents only through the CLEAR sweep.

Verification
REQ-033 Release rst, count cycles -> busy high for exactly 1024 cycles (defaults), then low; a read of 0xFFF returns 0x00.
REQ-034 Write 0xA5 to add=0x412, then read add=0x412 on the next cycle -> dout=0xA5 with dout_vld two cycles after the read is accepted.
REQ-035 Write 0x11/0x22/0x33/0x44 to 0x000/0x400/0x800/0xC00, then back-to-back reads -> dout sequence 0x11,0x22,0x33,0x44 on consecutive cycles.
REQ-036 rd=wr=1 with cen=0 at add=0x005 holding 0x5A -> err pulse, no dout_vld, and a later read still returns 0x5A.
REQ-037 Issue a read, then assert rst one cycle later -> no dout_vld, dout=0, busy=1, and the sweep restarts.
REQ-038 cen=1 with wr=1, din=0xFF at add=0x010 -> no err; a later read of 0x010 returns 0x00.

Source files
------------

// File: rtl/mem_bank_ctrl.sv
// Banked single-port word memory with a power-on/reset zeroing sweep and a
// fixed-latency, fully pipelined read path.
module mem_bank_ctrl #(
  parameter int DATA_W = 8,
  parameter int BANK_W = 2,
  parameter int OFF_W  = 10,
  parameter int RD_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cen,
  input  logic                      rd,
  input  logic                      wr,
  input  logic [BANK_W+OFF_W-1:0]   add,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_vld,
  output logic                      busy,
  output logic                      err
);

  localparam int ADDR_W = BANK_W + OFF_W;
  localparam int NBANK  = 1 << BANK_W;
  localparam int NWORD  = 1 << ADDR_W;

  localparam logic [0:0] S_CLEAR  = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              req, rd_acc, wr_acc;

  logic [DATA_W-1:0] mem_q [NWORD];

  // vld_q[0] / dat_q[0] hold the word sampled on the accepting edge;
  // vld_q[RD_LAT] qualifies the output register.
  logic [RD_LAT:0]   vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic [DATA_W-1:0] dout_q;

  always_comb begin
    req     = !cen && (rd || wr);
    rd_acc  = (state_q == S_ACTIVE) && !cen && rd && !wr;
    wr_acc  = (state_q == S_ACTIVE) && !cen && wr && !rd;
    err_d   = req && ((state_q == S_CLEAR) || (rd && wr));
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = S_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // The sweep zeroes one offset across all banks per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        for (int b = 0; b < NBANK; b++) mem_q[{BANK_W'(b), cnt_q}] <= '0;
      end else if (wr_acc) begin
        mem_q[add] <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[RD_LAT-1:0], rd_acc};
  end

  always_ff @(posedge clk) begin
    if (rd_acc) dat_q[0] <= mem_q[add];
    for (int i = 1; i < RD_LAT; i++) begin
      if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
    end
  end

  // Output register only moves on a completing read, so dout holds otherwise.
  always_ff @(posedge clk) begin
    if (rst)                    dout_q <= '0;
    else if (vld_q[RD_LAT-1])   dout_q <= dat_q[RD_LAT-1];
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q[RD_LAT];
  assign busy     = (state_q == S_CLEAR);
  assign err      = err_q;

endmodule
